// File: rtl/fir_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : fir_pkg                                                      |
// | Shared definitions for the FIR coefficient interface: default          |
// | coefficient width and tap count, load-sequencer state encoding, the    |
// | pass-through reset coefficient and a tap slice helper for coeff_flat.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package fir_pkg;

  localparam int COEF_W    = 16;
  localparam int N_DEFAULT = 10;

  // Tap 0 of the reset bank; every other tap resets to zero so the filter
  // passes its input straight through until a real bank is committed.
  localparam logic [COEF_W-1:0] TAP0_RST = COEF_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  // Bit position of tap k's LSB inside a flattened coefficient bank.
  function automatic int tap_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_cfg_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : fir_cfg_timer                                                |
// | Idle-cycle watchdog for the coefficient load sequence.                 |
// | Ports   : clk, rst_n      clock / async active-low reset               |
// |           clear_i         restart count from zero (has priority)       |
// |           enable_i        count this cycle                             |
// |           expired_o       one-cycle pulse on the cycle whose closing   |
// |                           edge would bring the count to TIMEOUT        |
// | TIMEOUT == 0 removes the counter and ties expired_o low.               |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module fir_cfg_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic w_unused;
      assign w_unused  = &{1'b0, clk, rst_n, clear_i, enable_i};
      assign expired_o = 1'b0;
    end else begin : g_on
      localparam int CNT_W = $clog2(TIMEOUT + 1);
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else if (clear_i) begin
          cnt_q <= '0;
        end else if (enable_i) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      // Fires while the count sits one below TIMEOUT so the owning FSM
      // leaves LOAD on exactly the edge the count reaches TIMEOUT.
      assign expired_o = enable_i && !clear_i && (cnt_q == CNT_W'(TIMEOUT - 1));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fir_coeff_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : fir_coeff_loader                                             |
// | Writer side of the FIR coefficient interface. Collects N words into a  |
// | shadow bank over a valid/ready stream, then commits them atomically to |
// | the active bank so the filter never sees a partial coefficient set.    |
// | Ports   : clk, rst_n          clock / async active-low reset           |
// |           cfg_start_i         pulse: begin (or restart) a load         |
// |           cfg_valid_i/ready_o beat handshake, cfg_data_i = word        |
// |           coeff_flat_o        active bank, tap k at [k*COEF_W+:COEF_W] |
// |           coeff_update_o      pulse in first cycle a new bank shows    |
// |           load_busy_o         load sequence in progress                |
// |           load_err_o          pulse on abort / timeout / bad checksum  |
// | Option  : define COEFF_CHKSUM_EN to require a trailing checksum word   |
// |           (mod 2^COEF_W sum of the taps) before commit.                |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int COEF_W  = fir_pkg::COEF_W,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [COEF_W-1:0]   cfg_data_i,
  output logic [N*COEF_W-1:0] coeff_flat_o,
  output logic                coeff_update_o,
  output logic                load_busy_o,
  output logic                load_err_o
);

  localparam int                 IDX_W    = $clog2(N + 1);
  localparam logic [N*COEF_W-1:0] BANK_RST = (N*COEF_W)'(TAP0_RST);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [COEF_W-1:0]     shadow_q [N];
  logic [N*COEF_W-1:0]   active_q;
  logic                  update_q, update_d;
  logic                  err_q, err_d;

  logic                  w_in_load;
  logic                  w_beat;
  logic                  w_last;
  logic                  w_restart;
  logic                  w_expired;
  logic                  w_chk_fail;
  logic [N*COEF_W-1:0]   w_shadow_flat;

`ifdef COEFF_CHKSUM_EN
  logic [COEF_W-1:0]     sum_q;
  logic                  w_chk_beat;
  assign w_in_load  = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  // A restart beat in CHECK is discarded, not judged.
  assign w_chk_beat = (state_q == ST_CHECK) && w_beat && !cfg_start_i;
  assign w_chk_fail = w_chk_beat && (cfg_data_i != sum_q);
`else
  assign w_in_load  = (state_q == ST_LOAD);
  assign w_chk_fail = 1'b0;
`endif

  assign w_beat    = cfg_valid_i && cfg_ready_o;
  assign w_last    = (state_q == ST_LOAD) && w_beat && !cfg_start_i &&
                     (idx_q == IDX_W'(N - 1));
  // Start is honoured everywhere except COMMIT.
  assign w_restart = cfg_start_i && (state_q != ST_COMMIT);

  fir_cfg_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (!w_in_load || w_beat || cfg_start_i),
    .enable_i  (w_in_load),
    .expired_o (w_expired)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start_i) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (cfg_start_i)    state_d = ST_LOAD;
        else if (w_expired) state_d = ST_IDLE;
`ifdef COEFF_CHKSUM_EN
        else if (w_last)    state_d = ST_CHECK;
`else
        else if (w_last)    state_d = ST_COMMIT;
`endif
      end
`ifdef COEFF_CHKSUM_EN
      ST_CHECK: begin
        if (cfg_start_i)     state_d = ST_LOAD;
        else if (w_expired)  state_d = ST_IDLE;
        else if (w_chk_beat) state_d = w_chk_fail ? ST_IDLE : ST_COMMIT;
      end
`endif
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    cfg_ready_o = w_in_load;
    load_busy_o = (state_q != ST_IDLE);
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    idx_d = idx_q;
    if (w_restart) begin
      idx_d = '0;
    end else if ((state_q == ST_LOAD) && w_beat) begin
      idx_d = w_last ? '0 : idx_q + 1'b1;
    end
    update_d = (state_q == ST_COMMIT);
    err_d    = w_in_load && (cfg_start_i || w_expired || w_chk_fail);
  end

  generate
    for (genvar k = 0; k < N; k++) begin : g_pack
      assign w_shadow_flat[tap_lsb(k, COEF_W) +: COEF_W] = shadow_q[k];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      active_q <= BANK_RST;
      update_q <= 1'b0;
      err_q    <= 1'b0;
      for (int k = 0; k < N; k++) shadow_q[k] <= '0;
    end else begin
      idx_q    <= idx_d;
      update_q <= update_d;
      err_q    <= err_d;
      for (int k = 0; k < N; k++) begin
        if ((state_q == ST_LOAD) && w_beat && !cfg_start_i && (idx_q == IDX_W'(k)))
          shadow_q[k] <= cfg_data_i;
      end
      if (state_q == ST_COMMIT) active_q <= w_shadow_flat;
    end
  end

`ifdef COEFF_CHKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (w_restart) begin
      sum_q <= '0;
    end else if ((state_q == ST_LOAD) && w_beat) begin
      sum_q <= sum_q + cfg_data_i;
    end
  end
`endif

  assign coeff_flat_o   = active_q;
  assign coeff_update_o = update_q;
  assign load_err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_coeff_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_fir_coeff_loader                                          |
// | Scoreboard bench for fir_coeff_loader: stimulus pushes expected banks  |
// | and error pulses (with their expected cycle) into queues; a negedge    |
// | monitor pops and compares whenever the DUT raises coeff_update/err.    |
// | Build with COEFF_CHKSUM_EN defined to cover the checksum option.       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_fir_coeff_loader;

  localparam int N  = 10;
  localparam int W  = 16;
  localparam int TO = 8;

  localparam logic [N*W-1:0] BANK_RST = 160'h0000_0000_0000_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [N*W-1:0] BANK_A   = 160'h000a_0009_0008_0007_0006_0005_0004_0003_0002_0001;
  localparam logic [N*W-1:0] BANK_C   = 160'h0100_0100_0100_0100_0100_0100_0100_0100_0100_0100;
  localparam logic [N*W-1:0] BANK_D   = 160'h002a_0029_0028_0027_0026_0025_0024_0023_0022_0021;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_start = 1'b0;
  logic           cfg_valid = 1'b0;
  logic [W-1:0]   cfg_data = '0;
  logic           cfg_ready;
  logic [N*W-1:0] coeff_flat;
  logic           coeff_update;
  logic           load_busy;
  logic           load_err;

  fir_coeff_loader #(
    .N       (N),
    .COEF_W  (W),
    .TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_start_i    (cfg_start),
    .cfg_valid_i    (cfg_valid),
    .cfg_ready_o    (cfg_ready),
    .cfg_data_i     (cfg_data),
    .coeff_flat_o   (coeff_flat),
    .coeff_update_o (coeff_update),
    .load_busy_o    (load_busy),
    .load_err_o     (load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int last_cyc = 0;

  typedef struct {
    logic [N*W-1:0] bank;
    int             at;
  } upd_t;

  upd_t           upd_q[$];
  int             err_q[$];
  upd_t           m_upd;
  int             m_err;
  logic [N*W-1:0] cur_bank = BANK_RST;
  logic [W-1:0]   va [N];
  logic [W-1:0]   vc [N];

  task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      cur_bank = BANK_RST;
    end else begin
      checks++;
      if (coeff_update) begin
        if (upd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_update cyc=%0d bank=%h required=no update", cyc, coeff_flat);
        end else begin
          m_upd = upd_q.pop_front();
          if (coeff_flat !== m_upd.bank || cyc != m_upd.at) begin
            errors++;
            $display("FAIL commit bank=%h cyc=%0d required bank=%h cyc=%0d",
                     coeff_flat, cyc, m_upd.bank, m_upd.at);
          end
          cur_bank = m_upd.bank;
        end
      end else if (coeff_flat !== cur_bank) begin
        errors++;
        $display("FAIL bank_stable cyc=%0d bank=%h required=%h", cyc, coeff_flat, cur_bank);
      end
      if (load_err) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_err cyc=%0d required=no error pulse", cyc);
        end else begin
          m_err = err_q.pop_front();
          if (cyc != m_err) begin
            errors++;
            $display("FAIL err_time cyc=%0d required cyc=%0d", cyc, m_err);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cfg_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic beat(input logic [W-1:0] d);
    cfg_valid = 1'b1;
    cfg_data  = d;
    chk("ready_in_load", {159'd0, cfg_ready}, 160'd1);
    tick();
    cfg_valid = 1'b0;
    last_cyc  = cyc;
  endtask

  task automatic load(input logic [W-1:0] v[N], input bit gap);
    logic [W-1:0] s = '0;
    do_start();
    for (int i = 0; i < N; i++) begin
      if (gap) begin
        cfg_valid = 1'b0;
        cfg_data  = 16'hDEAD;
        tick();
      end
      beat(v[i]);
      s = s + v[i];
    end
`ifdef COEFF_CHKSUM_EN
    beat(s);
`endif
  endtask

  task automatic push_upd(input logic [N*W-1:0] b, input int at);
    upd_t e;
    e.bank = b;
    e.at   = at;
    upd_q.push_back(e);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < N; i++) begin
      va[i] = W'(i + 1);
      vc[i] = 16'h0100;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flat",   coeff_flat, BANK_RST);
    chk("rst_update", {159'd0, coeff_update}, 160'd0);
    chk("rst_err",    {159'd0, load_err}, 160'd0);
    chk("rst_busy",   {159'd0, load_busy}, 160'd0);
    chk("rst_ready",  {159'd0, cfg_ready}, 160'd0);
    rst_n = 1'b1;
    tick();

    // cfg_valid in IDLE is ignored
    cfg_valid = 1'b1;
    cfg_data  = 16'h5555;
    tick();
    chk("idle_ready", {159'd0, cfg_ready}, 160'd0);
    chk("idle_busy",  {159'd0, load_busy}, 160'd0);
    idle(2);

    // Back-to-back load 1..10, bank visible two edges after last beat
    load(va, 1'b0);
    push_upd(BANK_A, last_cyc + 1);
    chk("busy_commit", {159'd0, load_busy}, 160'd1);
    idle(4);

    // cfg_valid toggling every other cycle
    load(va, 1'b1);
    push_upd(BANK_A, last_cyc + 1);
    idle(4);

    // Abort after 4 beats, then full load of 0x0100
    do_start();
    for (int i = 0; i < 4; i++) beat(W'(16'h0011 + i));
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 16'h7777;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    err_q.push_back(cyc);
    for (int i = 0; i < N; i++) beat(16'h0100);
`ifdef COEFF_CHKSUM_EN
    beat(16'h0A00);
`endif
    push_upd(BANK_C, last_cyc + 1);
    idle(4);

    // Timeout: 3 beats then an 8-cycle stall
    do_start();
    for (int i = 0; i < 3; i++) beat(16'h0BAD);
    err_q.push_back(last_cyc + TO);
    idle(TO);
    chk("to_busy",  {159'd0, load_busy}, 160'd0);
    chk("to_ready", {159'd0, cfg_ready}, 160'd0);
    chk("to_flat",  coeff_flat, BANK_C);
    idle(2);

    // 7-cycle stall is one short of the timeout
    do_start();
    for (int i = 0; i < 3; i++) beat(W'(16'h0021 + i));
    idle(TO - 1);
    chk("stall7_busy", {159'd0, load_busy}, 160'd1);
    for (int i = 3; i < N; i++) beat(W'(16'h0021 + i));
`ifdef COEFF_CHKSUM_EN
    beat(16'h0177);
`endif
    push_upd(BANK_D, last_cyc + 1);
    idle(4);

    // cfg_start during COMMIT is ignored
    load(va, 1'b0);
    push_upd(BANK_A, last_cyc + 1);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("commit_start_busy", {159'd0, load_busy}, 160'd0);
    idle(4);

`ifdef COEFF_CHKSUM_EN
    // Good checksum commits, bad checksum errors without commit
    load(vc, 1'b0);
    push_upd(BANK_C, last_cyc + 1);
    idle(4);
    do_start();
    for (int i = 0; i < N; i++) beat(va[i]);
    beat(16'd54);
    err_q.push_back(last_cyc);
    chk("badsum_busy", {159'd0, load_busy}, 160'd0);
    idle(4);
    load(va, 1'b0);
    push_upd(BANK_A, last_cyc + 1);
    idle(4);
`endif

    // Reset mid-load restores the pass-through bank
    do_start();
    for (int i = 0; i < 5; i++) beat(16'h0F0F);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_flat",  coeff_flat, BANK_RST);
    chk("midrst_busy",  {159'd0, load_busy}, 160'd0);
    chk("midrst_ready", {159'd0, cfg_ready}, 160'd0);
    tick();
    rst_n = 1'b1;
    idle(2);

    // Fresh load after reset
    load(vc, 1'b0);
    push_upd(BANK_C, last_cyc + 1);
    idle(6);

    chk("upd_queue_empty", 160'(upd_q.size()), 160'd0);
    chk("err_queue_empty", 160'(err_q.size()), 160'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
